// File: rtl/input_debouncer_pkg.sv
// Shared types and sizing helpers for the input debouncer and its users.
package input_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } debounce_state_t;

  // Counter must hold values up to STABLE_CYCLES inclusive.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for bringing an asynchronous level into the clk domain.
module sync_ff_chain #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a bouncing asynchronous level: synchronizer, stability-counting FSM,
// registered clean level plus single-cycle rise/fall pulses.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int   STABLE_CYCLES = 16,
  parameter int   SYNC_STAGES   = 2,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            raw_in,
  output logic            clean_out,
  output logic            rise_pulse,
  output logic            fall_pulse,
  output logic            busy,
  output debounce_state_t dbg_state
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam debounce_state_t RESET_STATE = RESET_LEVEL ? IDLE_HI : IDLE_LO;

  logic            s;
  debounce_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            clean_q, clean_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic            busy_q, busy_d;

  sync_ff_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (raw_in),
    .q     (s)
  );

  // Each WAIT state either bounces back to its IDLE or, on the last qualifying
  // edge, flips the clean level and lands in the opposite IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          clean_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          clean_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
        clean_d = RESET_LEVEL;
      end
    endcase
    busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      clean_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign clean_out  = clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer (STABLE_CYCLES=4, SYNC_STAGES=2, RESET_LEVEL=0).
module tb_input_debouncer;
  import input_debouncer_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            raw_in;
  logic            clean_out;
  logic            rise_pulse;
  logic            fall_pulse;
  logic            busy;
  debounce_state_t dbg_state;

  // Expected word per cycle: {clean_out, rise_pulse, fall_pulse, busy}.
  logic [3:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         errors = 0;

  logic [3:0] mon_exp;
  logic [3:0] mon_got;
  string      mon_name;
  logic       prev_rise = 1'b0;
  logic       prev_fall = 1'b0;

  logic [11:0] bounce_raw = 12'b1111_1110_1101;
  logic [3:0]  bounce_exp[12] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000,
                                  4'b0001, 4'b0001, 4'b0000, 4'b0001,
                                  4'b0001, 4'b0001, 4'b1100, 4'b1000};

  input_debouncer #(
    .STABLE_CYCLES (4),
    .SYNC_STAGES   (2),
    .RESET_LEVEL   (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_in     (raw_in),
    .clean_out  (clean_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge; queue the expectation for the next rising edge.
  task automatic step(input logic rst, input logic raw, input logic [3:0] e, input string nm);
    @(negedge clk);
    rst_n  = rst;
    raw_in = raw;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic hold(input logic rst, input logic raw, input logic [3:0] e, input int n,
                      input string nm);
    for (int i = 0; i < n; i++) step(rst, raw, e, nm);
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      mon_got = {clean_out, rise_pulse, fall_pulse, busy};
      if (exp_q.size() > 0) begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        checks++;
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL %s: got {clean,rise,fall,busy}=%b expected %b at %0t",
                   mon_name, mon_got, mon_exp, $time);
        end
      end
      checks++;
      if (rise_pulse === 1'b1 && fall_pulse === 1'b1) begin
        errors++;
        $display("FAIL pulse_overlap: rise=%b fall=%b expected not both 1 at %0t",
                 rise_pulse, fall_pulse, $time);
      end
      checks++;
      if ((rise_pulse === 1'b1 && prev_rise) || (fall_pulse === 1'b1 && prev_fall)) begin
        errors++;
        $display("FAIL pulse_width: rise=%b fall=%b high on two cycles, expected one at %0t",
                 rise_pulse, fall_pulse, $time);
      end
      prev_rise = (rise_pulse === 1'b1);
      prev_fall = (fall_pulse === 1'b1);
    end
  end

  // Stimulus
  initial begin
    rst_n  = 1'b0;
    raw_in = 1'b0;

    for (int i = 0; i < 6; i++) step(1'b0, 1'(i % 2 == 0), 4'b0000, "in_reset");
    hold(1'b1, 1'b0, 4'b0000, 4, "post_reset");

    hold(1'b1, 1'b1, 4'b0000, 2, "rise_sync");
    hold(1'b1, 1'b1, 4'b0001, 3, "rise_wait");
    step(1'b1, 1'b1, 4'b1100, "rise_edge");
    hold(1'b1, 1'b1, 4'b1000, 3, "rise_hold");

    hold(1'b1, 1'b0, 4'b1000, 2, "fall_sync");
    hold(1'b1, 1'b0, 4'b1001, 3, "fall_wait");
    step(1'b1, 1'b0, 4'b0010, "fall_edge");
    hold(1'b1, 1'b0, 4'b0000, 3, "fall_hold");

    hold(1'b1, 1'b1, 4'b0000, 2, "glitch_sync");
    step(1'b1, 1'b1, 4'b0001, "glitch_wait");
    hold(1'b1, 1'b0, 4'b0001, 2, "glitch_wait");
    hold(1'b1, 1'b0, 4'b0000, 3, "glitch_back");

    for (int i = 0; i < 12; i++) step(1'b1, bounce_raw[i], bounce_exp[i], "bounce");
    hold(1'b1, 1'b1, 4'b1000, 2, "bounce_hold");

    hold(1'b1, 1'b0, 4'b1000, 2, "fall2_sync");
    hold(1'b1, 1'b0, 4'b1001, 3, "fall2_wait");
    step(1'b1, 1'b0, 4'b0010, "fall2_edge");
    hold(1'b1, 1'b0, 4'b0000, 3, "fall2_hold");

    hold(1'b1, 1'b1, 4'b0000, 2, "midwait_sync");
    step(1'b1, 1'b1, 4'b0001, "midwait_cnt1");
    step(1'b1, 1'b1, 4'b0001, "midwait_cnt2");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({clean_out, rise_pulse, fall_pulse, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL midwait_async_reset: got %b expected 0000",
               {clean_out, rise_pulse, fall_pulse, busy});
    end
    hold(1'b0, 1'b1, 4'b0000, 2, "midwait_in_reset");
    hold(1'b1, 1'b0, 4'b0000, 6, "midwait_after");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
